// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_scan_controller
//  Description : Time-multiplexed scan driver for an N-digit common-anode FND
//                with PWM brightness, digit mask, blank and frame-synchronous
//                capture of the displayed data.
//  Revision    : 1.0  initial release
// ============================================================================
module fnd_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 1000,
    parameter int BRIGHT_W   = 3
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_blank,
    input  logic [BRIGHT_W-1:0]           i_bright,
    input  logic [NUM_DIGITS-1:0]         i_digit_mask,
    input  logic [4*NUM_DIGITS-1:0]       i_bcd,
    input  logic [NUM_DIGITS-1:0]         i_dp,
    output logic [NUM_DIGITS-1:0]         o_digit,
    output logic [3:0]                    o_bcd,
    output logic                          o_dp,
    output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx,
    output logic                          o_frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0]      c_div_max   = DIV_W'(DIV - 1);
    localparam logic [BRIGHT_W-1:0]   c_phase_max = '1;
    localparam logic [IDX_W-1:0]      c_idx_max   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_one       = NUM_DIGITS'(1);

    logic [DIV_W-1:0]        r_div_cnt;
    logic [BRIGHT_W-1:0]     r_phase_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_bcd_sh;
    logic [NUM_DIGITS-1:0]   r_dp_sh;
    logic [NUM_DIGITS-1:0]   r_mask_sh;

    logic                    w_div_max;
    logic                    w_phase_max;
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_bcd_arr [NUM_DIGITS];

    assign w_div_max   = (r_div_cnt == c_div_max);
    assign w_phase_max = (r_phase_cnt == c_phase_max);
    assign w_slot_end  = w_div_max && w_phase_max;
    assign w_frame_end = w_slot_end && (r_idx == c_idx_max);

    // Clock divider: one brightness phase every DIV clocks.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div_cnt <= '0;
        end else if (w_div_max) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Phase counter is a power of two wide, so it wraps naturally.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phase_cnt <= '0;
        end else if (w_div_max) begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx <= '0;
        end else if (w_slot_end) begin
            if (r_idx == c_idx_max) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Display data is sampled only at the frame boundary to avoid tearing.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bcd_sh  <= '0;
            r_dp_sh   <= '0;
            r_mask_sh <= '0;
        end else if (w_frame_end) begin
            r_bcd_sh  <= i_bcd;
            r_dp_sh   <= i_dp;
            r_mask_sh <= i_digit_mask;
        end
    end

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_bcd_unpack
            assign w_bcd_arr[k] = r_bcd_sh[4*k +: 4];
        end
    endgenerate

    assign w_onehot = c_one << r_idx;
    assign w_lit    = !i_blank && r_mask_sh[r_idx] && (r_phase_cnt <= i_bright);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_digit      <= '1;
            o_bcd        <= '0;
            o_dp         <= 1'b0;
            o_digit_idx  <= '0;
            o_frame_tick <= 1'b0;
        end else begin
            o_digit      <= ~(w_onehot & {NUM_DIGITS{w_lit}});
            o_bcd        <= w_bcd_arr[r_idx];
            o_dp         <= r_dp_sh[r_idx];
            o_digit_idx  <= r_idx;
            o_frame_tick <= w_frame_end;
        end
    end

endmodule
`default_nettype wire
